// File: rtl/adder_tree_reduce_ctrl_pkg.sv
// Shared types and sizes for the adder-tree reduction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_tree_reduce_ctrl_pkg;
  localparam int ACC_DATA_WIDTH   = 32;
  localparam int ADDER_TREE_LANES = 8;

  typedef enum logic [1:0] {RED_IDLE, RED_RUN, RED_OUT} red_state_t;
endpackage

// File: rtl/adder_tree_reduce_ctrl_if.sv
// Beat input stream and reduced-sum output stream of the reduction controller.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; slave = reducer side.
interface adder_tree_reduce_ctrl_if;
  import adder_tree_reduce_ctrl_pkg::*;

  logic                                         in_valid_i;
  logic                                         in_ready_o;
  logic [ADDER_TREE_LANES*ACC_DATA_WIDTH-1:0]   in_data_i;
  logic                                         out_valid_o;
  logic                                         out_ready_i;
  logic [ACC_DATA_WIDTH-1:0]                    out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/adder_tree.sv
// Combinational 8-input signed adder tree, wrapping modulo 2^ACC_DATA_WIDTH.
// Latency: 0 cycles.
// Backpressure: none; operands forced to zero when use_adder_tree is low.
module adder_tree
  import adder_tree_reduce_ctrl_pkg::*;
(
  input  logic                             use_adder_tree,
  input  logic signed [ACC_DATA_WIDTH-1:0] operands [ADDER_TREE_LANES],
  output logic signed [ACC_DATA_WIDTH-1:0] sum
);
  logic signed [ACC_DATA_WIDTH-1:0] gated [ADDER_TREE_LANES];
  logic signed [ACC_DATA_WIDTH-1:0] lvl1  [4];
  logic signed [ACC_DATA_WIDTH-1:0] lvl2  [2];

  // Gate operands so the tree stays quiet when nothing is transferring, then add pairwise.
  always_comb begin
    for (int k = 0; k < ADDER_TREE_LANES; k++) begin
      gated[k] = use_adder_tree ? operands[k] : '0;
    end
    for (int k = 0; k < 4; k++) begin
      lvl1[k] = gated[2*k] + gated[2*k+1];
    end
    for (int k = 0; k < 2; k++) begin
      lvl2[k] = lvl1[2*k] + lvl1[2*k+1];
    end
    sum = lvl2[0] + lvl2[1];
  end
endmodule

// File: rtl/adder_tree_reduce_ctrl.sv
// Reduces cfg_num_beats 8-lane beats through the adder tree into one wrapped signed sum.
// Latency: result valid the cycle after the last beat is accepted; 1 beat/cycle in RUN.
// Backpressure: in_ready only in RUN; result held in OUT until out_ready.
module adder_tree_reduce_ctrl
  import adder_tree_reduce_ctrl_pkg::*;
#(
  parameter int BEAT_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [BEAT_CNT_W-1:0] cfg_num_beats_i,
  output logic                  busy_o,
  adder_tree_reduce_ctrl_if.slave bus
);
  localparam int LANES = ADDER_TREE_LANES;
  localparam int W     = ACC_DATA_WIDTH;

  red_state_t              state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beats_q, beat_cnt_q;
  logic signed [W-1:0]     acc_q;
  logic signed [W-1:0]     tree_sum;
  logic signed [W-1:0]     lanes [LANES];
  logic                    use_adder_tree;
  logic                    last_beat;

  // Unpack the flat beat bus into signed lanes for the tree.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lanes[k] = bus.in_data_i[k*W +: W];
    end
  end

  assign use_adder_tree = bus.in_valid_i && bus.in_ready_o;
  assign last_beat      = (beat_cnt_q == beats_q - 1'b1);
  assign bus.out_data_o = acc_q;

  adder_tree u_adder_tree (
    .use_adder_tree (use_adder_tree),
    .operands       (lanes),
    .sum            (tree_sum)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RED_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RED_IDLE: if (start_i) state_d = (cfg_num_beats_i == '0) ? RED_OUT : RED_RUN;
      RED_RUN:  if (use_adder_tree && last_beat) state_d = RED_OUT;
      RED_OUT:  if (bus.out_valid_o && bus.out_ready_i) state_d = RED_IDLE;
      default:  state_d = RED_IDLE;
    endcase
    if (clear_i) state_d = RED_IDLE;
  end

  // Outputs decoded from state; ready is dropped during clear so an aborted beat is never taken.
  always_comb begin
    busy_o          = (state_q != RED_IDLE);
    bus.in_ready_o  = (state_q == RED_RUN) && !clear_i;
    bus.out_valid_o = (state_q == RED_OUT);
  end

  // Beat counter and accumulator; cleared on start and on abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_q    <= '0;
      beat_cnt_q <= '0;
      acc_q      <= '0;
    end else if (clear_i) begin
      beat_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      case (state_q)
        RED_IDLE: if (start_i) begin
          beats_q    <= cfg_num_beats_i;
          beat_cnt_q <= '0;
          acc_q      <= '0;
        end
        RED_RUN: if (use_adder_tree) begin
          acc_q      <= acc_q + tree_sum;
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_tree_reduce_ctrl.sv
// Scoreboard bench for adder_tree_reduce_ctrl: expected sums queued at start, checked on output handshake.
// Latency: n/a.
// Backpressure: exercises out_ready low, in_valid gaps, clear and async reset mid-reduction.
module tb_adder_tree_reduce_ctrl;
  import adder_tree_reduce_ctrl_pkg::*;

  localparam int W = ACC_DATA_WIDTH;
  localparam int L = ADDER_TREE_LANES;

  typedef logic [W-1:0] lane_arr_t [L];

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       start;
  logic [7:0] cfg_beats;
  logic       busy;

  adder_tree_reduce_ctrl_if bus ();

  adder_tree_reduce_ctrl #(.BEAT_CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .cfg_num_beats_i (cfg_beats),
    .busy_o          (busy),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int out_cnt  = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: count input handshakes and score output handshakes.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (bus.in_valid_i && bus.in_ready_o) hs_cnt++;
      if (bus.out_valid_o && bus.out_ready_i) begin
        check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data_o), 64'(e));
        end
        out_cnt++;
      end
    end
  end

  function automatic lane_arr_t fill(input logic [W-1:0] v);
    lane_arr_t a;
    for (int k = 0; k < L; k++) a[k] = v;
    return a;
  endfunction

  function automatic logic [W-1:0] model_sum(input lane_arr_t a, input int beats);
    logic [W-1:0] s = '0;
    for (int b = 0; b < beats; b++)
      for (int k = 0; k < L; k++) s = s + a[k];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] beats);
    start     = 1'b1;
    cfg_beats = beats;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_beat(input lane_arr_t a);
    logic r;
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < L; k++) bus.in_data_i[k*W +: W] = a[k];
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = bus.in_ready_o;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid_i = 1'b0;
    check("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_out(input int prev);
    for (int i = 0; i < 20; i++) begin
      if (out_cnt > prev) break;
      tick();
    end
    check("out_arrive", 64'(out_cnt - prev), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lane_arr_t a;
    int prev;
    int hs0;

    rst_n = 1'b0; clear = 1'b0; start = 1'b0; cfg_beats = '0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b1;
    #3;
    check("rst_busy",   64'(busy),            64'd0);
    check("rst_ready",  64'(bus.in_ready_o),  64'd0);
    check("rst_valid",  64'(bus.out_valid_o), 64'd0);
    check("rst_data",   64'(bus.out_data_o),  64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: single beat, lanes 1..8, one-cycle latency.
    for (int k = 0; k < L; k++) a[k] = W'(k + 1);
    exp_q.push_back(model_sum(a, 1));
    prev = out_cnt;
    do_start(8'd1);
    check("t1_busy", 64'(busy), 64'd1);
    send_beat(a);
    @(negedge clk);
    check("t1_latency", 64'(bus.out_valid_o), 64'd1);
    wait_out(prev);

    // 2: three beats of -5 with in_valid gaps, extra valid after completion ignored.
    a = fill(-32'sd5);
    exp_q.push_back(model_sum(a, 3));
    prev = out_cnt;
    hs0  = hs_cnt;
    do_start(8'd3);
    for (int b = 0; b < 3; b++) begin
      send_beat(a);
      tick();
    end
    wait_out(prev);
    bus.in_valid_i = 1'b1;
    repeat (2) tick();
    bus.in_valid_i = 1'b0;
    check("t2_handshakes", 64'(hs_cnt - hs0), 64'd3);

    // 3: wrapping sum with output backpressure.
    a = fill(32'h1000_0000);
    exp_q.push_back(model_sum(a, 2));
    bus.out_ready_i = 1'b0;
    do_start(8'd2);
    send_beat(a);
    send_beat(a);
    prev = out_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_valid_hold", 64'(bus.out_valid_o), 64'd1);
      check("t3_data_hold",  64'(bus.out_data_o),  64'(model_sum(a, 2)));
      check("t3_no_ready",   64'(bus.in_ready_o),  64'd0);
    end
    tick();
    bus.out_ready_i = 1'b1;
    wait_out(prev);

    // 4: zero beats -> immediate zero result, no beat ever requested.
    exp_q.push_back('0);
    prev = out_cnt;
    hs0  = hs_cnt;
    bus.in_valid_i = 1'b1;
    do_start(8'd0);
    @(negedge clk);
    check("t4_valid", 64'(bus.out_valid_o), 64'd1);
    check("t4_ready", 64'(bus.in_ready_o),  64'd0);
    wait_out(prev);
    bus.in_valid_i = 1'b0;
    check("t4_no_beats", 64'(hs_cnt - hs0), 64'd0);

    // 5: clear after two of four beats; beat in clear cycle not taken; restart clean.
    a = fill(32'd3);
    do_start(8'd4);
    send_beat(a);
    send_beat(a);
    hs0 = hs_cnt;
    for (int k = 0; k < L; k++) bus.in_data_i[k*W +: W] = a[k];
    bus.in_valid_i = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check("t5_clr_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    clear = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("t5_idle_busy",  64'(busy),            64'd0);
    check("t5_idle_valid", 64'(bus.out_valid_o), 64'd0);
    check("t5_clr_nobeat", 64'(hs_cnt - hs0),    64'd0);
    tick();
    a = fill(32'd1);
    exp_q.push_back(model_sum(a, 1));
    prev = out_cnt;
    do_start(8'd1);
    send_beat(a);
    wait_out(prev);

    // 6: async reset mid-run, then restart.
    a = fill(32'd7);
    do_start(8'd3);
    send_beat(a);
    check("t6_busy_run", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_busy",  64'(busy),            64'd0);
    check("t6_rst_ready", 64'(bus.in_ready_o),  64'd0);
    check("t6_rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("t6_rst_data",  64'(bus.out_data_o),  64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    a = fill(32'd2);
    exp_q.push_back(model_sum(a, 1));
    prev = out_cnt;
    do_start(8'd1);
    send_beat(a);
    wait_out(prev);

    repeat (3) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
